scores_writer: RTL and testbench
================================

Name: scores_writer

Overview:
- Game-over stage that sits downstream of the high-score reader. Compares the final score with the previous best from the reader (PREVIOUS_SCORES, valid when READ_FINISH=1).
- On a new record, issues a single-word write to the SD controller at the score slot, then reports completion.
- Feeds the SD write port and the end-of-game display (NEW_RECORD, BEST_SCORE).

Parameters:
- SCORES_ADDRESS, 32'h0000_2000: SD write address. Must equal the address the reader uses.
- TIMEOUT_CYCLES, 1024: cycles to wait in REQUEST for SD_IS_WRITING before a retry. Range 2..65535.
- MAX_RETRY, 3: total write attempts before declaring an error. Range 1..7.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- TO_SAVE  in  1  game over; level, sampled in IDLE
- CURRENT_SCORE  in  16  final score of this game, unsigned
- PREVIOUS_SCORES  in  16  stored best from the reader, unsigned
- READ_FINISH  in  1  PREVIOUS_SCORES valid
- SD_HAS_INITIALIZED  in  1  SD controller ready
- SD_IS_WRITING  in  1  SD controller busy writing
- SD_TO_WRITE  out  1  write request to the SD controller
- SD_WRITE_ADDRESS  out  32  constant SCORES_ADDRESS
- WRITE_DATA  out  16  score to write
- WRITE_FINISH  out  1  sequence complete (written or skipped)
- NEW_RECORD  out  1  CURRENT_SCORE beat the previous best
- WRITE_ERROR  out  1  retries exhausted
- BEST_SCORE  out  16  best score after this game

Behaviour:
- All outputs are registered and decoded from the state register.
- Reset values: SD_TO_WRITE=0, WRITE_DATA=0, WRITE_FINISH=0, NEW_RECORD=0, WRITE_ERROR=0, BEST_SCORE=0, state=IDLE, retry count=0, timer=0.
- Asserting RESET in any state, including mid-write, returns to IDLE immediately. SD_TO_WRITE drops asynchronously.
- States and transitions:
  - IDLE:
    - TO_SAVE=1 latches CURRENT_SCORE into score_latch and goes to WAIT_PREV.
    - Later changes to CURRENT_SCORE are ignored.
  - WAIT_PREV: waits for READ_FINISH=1, then goes to COMPARE.
  - COMPARE (1 cycle): unsigned compare.
    - score_latch > PREVIOUS_SCORES: go to WAIT_SD.
    - Otherwise go to SKIP. Equal scores count as no record.
  - WAIT_SD: waits for SD_HAS_INITIALIZED=1 and SD_IS_WRITING=0, then goes to REQUEST.
  - REQUEST:
    - SD_TO_WRITE=1 and WRITE_DATA=score_latch.
    - SD_IS_WRITING=1: go to WAIT_WRITE_FINISH and clear the timer.
    - Timer reaches TIMEOUT_CYCLES-1: increment retry count.
      - Retry count now equals MAX_RETRY: go to ERROR.
      - Otherwise go to BACKOFF.
  - BACKOFF (1 cycle): SD_TO_WRITE=0, then go to WAIT_SD.
  - WAIT_WRITE_FINISH:
    - SD_TO_WRITE=0. WRITE_DATA holds score_latch.
    - SD_IS_WRITING=0: go to DONE. No timeout in this state.
  - DONE (sticky): WRITE_FINISH=1, NEW_RECORD=1, BEST_SCORE=score_latch.
  - SKIP (sticky): WRITE_FINISH=1, NEW_RECORD=0, BEST_SCORE=PREVIOUS_SCORES captured at COMPARE.
  - ERROR (sticky): WRITE_ERROR=1, WRITE_FINISH=0, BEST_SCORE=PREVIOUS_SCORES captured at COMPARE.
- Sticky states are left only by reset. TO_SAVE has no effect outside IDLE.
- SD_TO_WRITE is high only in REQUEST. It rises the cycle after entering REQUEST and falls the cycle after SD_IS_WRITING is seen high.
- Minimum latency, TO_SAVE to WRITE_FINISH on the skip path (READ_FINISH already 1): 4 clock edges (IDLE, WAIT_PREV, COMPARE, SKIP).
- SD_IS_WRITING=1 while in WAIT_SD: stay in WAIT_SD. The request is never raised while the controller is busy.
- Retry count is 3 bits wide and saturates; timer is 16 bits wide.

Optional Feature:
- Macro: SCORES_ALWAYS_WRITE_EN.
- Defined: COMPARE always goes to WAIT_SD, so the latched score is written even when it is lower than the previous best. This is used to clear or reset the stored record. NEW_RECORD still reports the true compare result (score_latch > PREVIOUS_SCORES). In DONE, BEST_SCORE=score_latch.
- Undefined: behaviour exactly as above, and SKIP is reachable.

Test Plan:
- Record path: PREVIOUS_SCORES=100, READ_FINISH=1, CURRENT_SCORE=250, pulse TO_SAVE; model raises SD_IS_WRITING 3 cycles after SD_TO_WRITE and holds it 10 cycles -> SD_TO_WRITE high for exactly 4 cycles, WRITE_DATA=250, then WRITE_FINISH=1, NEW_RECORD=1, BEST_SCORE=250.
- Skip and equal: PREVIOUS_SCORES=300, CURRENT_SCORE=300 -> SD_TO_WRITE never rises, WRITE_FINISH=1 within 4 edges, NEW_RECORD=0, BEST_SCORE=300.
- Late reader: TO_SAVE with READ_FINISH=0 for 50 cycles, then READ_FINISH=1 with PREVIOUS_SCORES=10, CURRENT_SCORE=11 -> no request before READ_FINISH; write of 11 completes afterwards.
- Timeout and retry: TIMEOUT_CYCLES=8, MAX_RETRY=3, model never answers -> 3 request bursts of 8 cycles, each separated by a low gap of at least 1 cycle, then WRITE_ERROR=1, WRITE_FINISH=0, BEST_SCORE=PREVIOUS_SCORES.
- Reset mid-write: drive RESET=0 while in WAIT_WRITE_FINISH -> all outputs return to reset values asynchronously; after release, a new TO_SAVE runs the full sequence again.
- SCORES_ALWAYS_WRITE_EN defined: PREVIOUS_SCORES=500, CURRENT_SCORE=20 -> write of 20 occurs, NEW_RECORD=0, BEST_SCORE=20.

Source files
------------

// File: rtl/scores_writer.sv
// scores_writer: game-over stage that compares the final score with the stored
// best and, on a new record, issues one SD write to SCORES_ADDRESS with bounded
// retries. All outputs are registered and decoded from the state register.
// Optional build macro SCORES_ALWAYS_WRITE_EN: always write the latched score,
// even when it does not beat the stored best (used to clear the record).
module scores_writer #(
  parameter logic [31:0] SCORES_ADDRESS = 32'h0000_2000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TO_SAVE,
  input  logic [15:0] CURRENT_SCORE,
  input  logic [15:0] PREVIOUS_SCORES,
  input  logic        READ_FINISH,
  input  logic        SD_HAS_INITIALIZED,
  input  logic        SD_IS_WRITING,
  output logic        SD_TO_WRITE,
  output logic [31:0] SD_WRITE_ADDRESS,
  output logic [15:0] WRITE_DATA,
  output logic        WRITE_FINISH,
  output logic        NEW_RECORD,
  output logic        WRITE_ERROR,
  output logic [15:0] BEST_SCORE
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_PREV,
    S_COMPARE,
    S_WAIT_SD,
    S_REQUEST,
    S_BACKOFF,
    S_WAIT_WRITE_FINISH,
    S_DONE,
    S_SKIP,
    S_ERROR
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  RETRY_LIM  = 3'(MAX_RETRY);

  state_t      state_q;
  logic [2:0]  retry_q;
  logic [2:0]  retry_d;
  logic [15:0] timer_q;

  logic [15:0] score_latch_q;
  logic [15:0] prev_latch_q;
  logic        record_q;

  logic        sd_to_write_q;
  logic [15:0] write_data_q;
  logic        write_finish_q;
  logic        new_record_q;
  logic        write_error_q;
  logic [15:0] best_score_q;

  // Saturating next value of the attempt counter.
  assign retry_d = (retry_q == 3'd7) ? 3'd7 : retry_q + 3'd1;

  // Score and compare-result capture; pure datapath, no reset needed.
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && TO_SAVE) begin
      score_latch_q <= CURRENT_SCORE;
    end
    if (state_q == S_COMPARE) begin
      prev_latch_q <= PREVIOUS_SCORES;
      record_q     <= (score_latch_q > PREVIOUS_SCORES);
    end
  end

  // Control FSM with outputs registered from the current state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q        <= S_IDLE;
      retry_q        <= 3'd0;
      timer_q        <= 16'd0;
      sd_to_write_q  <= 1'b0;
      write_data_q   <= 16'd0;
      write_finish_q <= 1'b0;
      new_record_q   <= 1'b0;
      write_error_q  <= 1'b0;
      best_score_q   <= 16'd0;
    end else begin
      sd_to_write_q  <= (state_q == S_REQUEST);
      write_finish_q <= (state_q == S_DONE) || (state_q == S_SKIP);
      write_error_q  <= (state_q == S_ERROR);
      new_record_q   <= (state_q == S_DONE) && record_q;
      if (state_q == S_REQUEST) begin
        write_data_q <= score_latch_q;
      end
      if (state_q == S_DONE) begin
        best_score_q <= score_latch_q;
      end else if (state_q == S_SKIP || state_q == S_ERROR) begin
        best_score_q <= prev_latch_q;
      end

      case (state_q)
        S_IDLE: begin
          if (TO_SAVE) state_q <= S_WAIT_PREV;
        end
        S_WAIT_PREV: begin
          if (READ_FINISH) state_q <= S_COMPARE;
        end
        S_COMPARE: begin
`ifdef SCORES_ALWAYS_WRITE_EN
          state_q <= S_WAIT_SD;
`else
          // Equal scores are not a record.
          state_q <= (score_latch_q > PREVIOUS_SCORES) ? S_WAIT_SD : S_SKIP;
`endif
        end
        S_WAIT_SD: begin
          if (SD_HAS_INITIALIZED && !SD_IS_WRITING) state_q <= S_REQUEST;
        end
        S_REQUEST: begin
          if (SD_IS_WRITING) begin
            timer_q <= 16'd0;
            state_q <= S_WAIT_WRITE_FINISH;
          end else if (timer_q == TIMER_LAST) begin
            timer_q <= 16'd0;
            retry_q <= retry_d;
            state_q <= (retry_d == RETRY_LIM) ? S_ERROR : S_BACKOFF;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        S_BACKOFF: begin
          state_q <= S_WAIT_SD;
        end
        S_WAIT_WRITE_FINISH: begin
          if (!SD_IS_WRITING) state_q <= S_DONE;
        end
        S_DONE, S_SKIP, S_ERROR: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign SD_TO_WRITE      = sd_to_write_q;
  assign SD_WRITE_ADDRESS = SCORES_ADDRESS;
  assign WRITE_DATA       = write_data_q;
  assign WRITE_FINISH     = write_finish_q;
  assign NEW_RECORD       = new_record_q;
  assign WRITE_ERROR      = write_error_q;
  assign BEST_SCORE       = best_score_q;

endmodule

// File: tb/tb_scores_writer.sv
// Directed bench for scores_writer with a small SD-controller model and a
// queue of expected write data consumed on every write request.
module tb_scores_writer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        TO_SAVE = 1'b0;
  logic [15:0] CURRENT_SCORE = 16'd0;
  logic [15:0] PREVIOUS_SCORES = 16'd0;
  logic        READ_FINISH = 1'b0;
  logic        SD_HAS_INITIALIZED = 1'b1;
  logic        sd_is_writing = 1'b0;
  logic        SD_TO_WRITE;
  logic [31:0] SD_WRITE_ADDRESS;
  logic [15:0] WRITE_DATA;
  logic        WRITE_FINISH;
  logic        NEW_RECORD;
  logic        WRITE_ERROR;
  logic [15:0] BEST_SCORE;

  int pass_cnt = 0;
  int fail_cnt = 0;

  // Scoreboard and request-burst observations.
  logic [31:0] exp_q[$];
  int          bursts[$];
  int          gaps[$];
  int          run = 0;
  int          low_run = 0;
  bit          seen_burst = 0;
  bit          prev_w = 0;

  // SD model state.
  bit model_on = 0;
  int hi_cnt = 0;
  int busy_cnt = 0;

  scores_writer #(
    .SCORES_ADDRESS(32'h0000_2000),
    .TIMEOUT_CYCLES(8),
    .MAX_RETRY(3)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .TO_SAVE(TO_SAVE),
    .CURRENT_SCORE(CURRENT_SCORE),
    .PREVIOUS_SCORES(PREVIOUS_SCORES),
    .READ_FINISH(READ_FINISH),
    .SD_HAS_INITIALIZED(SD_HAS_INITIALIZED),
    .SD_IS_WRITING(sd_is_writing),
    .SD_TO_WRITE(SD_TO_WRITE),
    .SD_WRITE_ADDRESS(SD_WRITE_ADDRESS),
    .WRITE_DATA(WRITE_DATA),
    .WRITE_FINISH(WRITE_FINISH),
    .NEW_RECORD(NEW_RECORD),
    .WRITE_ERROR(WRITE_ERROR),
    .BEST_SCORE(BEST_SCORE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SD model: busy is raised during the third cycle the request is seen high
  // and held for 10 cycles.
  initial forever begin
    @(posedge CLK);
    #1;
    if (model_on) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) sd_is_writing = 1'b0;
      end else if (SD_TO_WRITE) begin
        hi_cnt++;
        if (hi_cnt == 3) begin
          sd_is_writing = 1'b1;
          busy_cnt = 10;
          hi_cnt = 0;
        end
      end
    end
  end

  // Request monitor: pops expected data on each rising request, logs burst
  // lengths and the low gaps between bursts.
  always @(negedge CLK) begin
    logic [31:0] e;
    if (!RESET) begin
      prev_w = 0;
    end else begin
      if (SD_TO_WRITE && !prev_w) begin
        if (seen_burst) gaps.push_back(low_run);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("req_data", {16'd0, WRITE_DATA}, e);
        run = 1;
      end else if (SD_TO_WRITE) begin
        run++;
      end else if (prev_w) begin
        bursts.push_back(run);
        seen_burst = 1;
        low_run = 1;
      end else begin
        low_run++;
      end
      prev_w = SD_TO_WRITE;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    model_on = 0;
    hi_cnt = 0;
    busy_cnt = 0;
    sd_is_writing = 1'b0;
    TO_SAVE = 1'b0;
    @(negedge CLK);
    exp_q.delete();
    bursts.delete();
    gaps.delete();
    seen_burst = 0;
    low_run = 0;
    run = 0;
    RESET = 1'b1;
  endtask

  task automatic pulse_save(input logic [15:0] score);
    @(negedge CLK);
    CURRENT_SCORE = score;
    TO_SAVE = 1'b1;
    @(negedge CLK);
    TO_SAVE = 1'b0;
    CURRENT_SCORE = 16'hFFFF;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(WRITE_FINISH || WRITE_ERROR) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_finished_in_budget"}, {31'd0, n < 400}, 32'd1);
  endtask

  initial begin
    // Reset values, asserted asynchronously before any clock edge.
    #3 RESET = 1'b0;
    #2;
    check("rst_to_write", {31'd0, SD_TO_WRITE}, 32'd0);
    check("rst_data", {16'd0, WRITE_DATA}, 32'd0);
    check("rst_finish", {31'd0, WRITE_FINISH}, 32'd0);
    check("rst_record", {31'd0, NEW_RECORD}, 32'd0);
    check("rst_error", {31'd0, WRITE_ERROR}, 32'd0);
    check("rst_best", {16'd0, BEST_SCORE}, 32'd0);
    check("address", SD_WRITE_ADDRESS, 32'h0000_2000);
    @(negedge CLK);
    RESET = 1'b1;

    // Record path.
    do_reset();
    model_on = 1;
    PREVIOUS_SCORES = 16'd100;
    READ_FINISH = 1'b1;
    exp_q.push_back(32'd250);
    pulse_save(16'd250);
    wait_done("record");
    repeat (2) @(negedge CLK);
    check("rec_finish", {31'd0, WRITE_FINISH}, 32'd1);
    check("rec_new", {31'd0, NEW_RECORD}, 32'd1);
    check("rec_best", {16'd0, BEST_SCORE}, 32'd250);
    check("rec_error", {31'd0, WRITE_ERROR}, 32'd0);
    check("rec_bursts", bursts.size(), 32'd1);
    if (bursts.size() > 0) check("rec_burst_len", bursts[0], 32'd4);
    check("rec_data_hold", {16'd0, WRITE_DATA}, 32'd250);
    check("rec_queue_empty", exp_q.size(), 32'd0);

    // Equal scores: no record, exact latency of 4 edges.
    do_reset();
    model_on = 1;
    PREVIOUS_SCORES = 16'd300;
    READ_FINISH = 1'b1;
`ifdef SCORES_ALWAYS_WRITE_EN
    exp_q.push_back(32'd300);
    pulse_save(16'd300);
    wait_done("equal");
    repeat (2) @(negedge CLK);
    check("eq_bursts", bursts.size(), 32'd1);
`else
    @(negedge CLK);
    CURRENT_SCORE = 16'd300;
    TO_SAVE = 1'b1;
    @(negedge CLK);
    TO_SAVE = 1'b0;
    repeat (2) @(negedge CLK);
    check("eq_finish_edge3", {31'd0, WRITE_FINISH}, 32'd0);
    @(negedge CLK);
    check("eq_finish_edge4", {31'd0, WRITE_FINISH}, 32'd1);
    repeat (5) @(negedge CLK);
    check("eq_bursts", bursts.size(), 32'd0);
`endif
    check("eq_new", {31'd0, NEW_RECORD}, 32'd0);
    check("eq_best", {16'd0, BEST_SCORE}, 32'd300);

    // Late reader, then a busy controller holding off the request.
    do_reset();
    model_on = 0;
    READ_FINISH = 1'b0;
    PREVIOUS_SCORES = 16'd9999;
    exp_q.push_back(32'd11);
    pulse_save(16'd11);
    repeat (50) @(negedge CLK);
    check("late_no_req", bursts.size() + {31'd0, SD_TO_WRITE}, 32'd0);
    check("late_no_finish", {31'd0, WRITE_FINISH}, 32'd0);
    sd_is_writing = 1'b1;
    PREVIOUS_SCORES = 16'd10;
    READ_FINISH = 1'b1;
    repeat (20) @(negedge CLK);
    check("busy_no_req", bursts.size() + {31'd0, SD_TO_WRITE}, 32'd0);
    sd_is_writing = 1'b0;
    model_on = 1;
    wait_done("late");
    repeat (2) @(negedge CLK);
    check("late_new", {31'd0, NEW_RECORD}, 32'd1);
    check("late_best", {16'd0, BEST_SCORE}, 32'd11);
    check("late_bursts", bursts.size(), 32'd1);

    // Timeout and retry with a silent controller.
    do_reset();
    model_on = 0;
    PREVIOUS_SCORES = 16'd40;
    READ_FINISH = 1'b1;
    repeat (3) exp_q.push_back(32'd90);
    pulse_save(16'd90);
    wait_done("timeout");
    repeat (2) @(negedge CLK);
    check("to_error", {31'd0, WRITE_ERROR}, 32'd1);
    check("to_finish", {31'd0, WRITE_FINISH}, 32'd0);
    check("to_best", {16'd0, BEST_SCORE}, 32'd40);
    check("to_new", {31'd0, NEW_RECORD}, 32'd0);
    check("to_bursts", bursts.size(), 32'd3);
    foreach (bursts[i]) check("to_burst_len", bursts[i], 32'd8);
    check("to_gaps", gaps.size(), 32'd2);
    foreach (gaps[i]) check("to_gap_ge1", {31'd0, gaps[i] >= 1}, 32'd1);
    TO_SAVE = 1'b1;
    repeat (20) @(negedge CLK);
    TO_SAVE = 1'b0;
    check("to_sticky_error", {31'd0, WRITE_ERROR}, 32'd1);
    check("to_sticky_bursts", bursts.size(), 32'd3);

    // Reset during WAIT_WRITE_FINISH, then a full new sequence.
    do_reset();
    model_on = 1;
    PREVIOUS_SCORES = 16'd5;
    READ_FINISH = 1'b1;
    exp_q.push_back(32'd77);
    pulse_save(16'd77);
    begin
      int n;
      n = 0;
      while (bursts.size() == 0 && n < 100) begin
        @(negedge CLK);
        n++;
      end
      check("mid_reached_wait", {31'd0, bursts.size() == 1 && sd_is_writing}, 32'd1);
    end
    #2 RESET = 1'b0;
    #1;
    check("mid_to_write", {31'd0, SD_TO_WRITE}, 32'd0);
    check("mid_data", {16'd0, WRITE_DATA}, 32'd0);
    check("mid_finish", {31'd0, WRITE_FINISH}, 32'd0);
    check("mid_best", {16'd0, BEST_SCORE}, 32'd0);
    do_reset();
    model_on = 1;
    exp_q.push_back(32'd123);
    pulse_save(16'd123);
    wait_done("after_reset");
    repeat (2) @(negedge CLK);
    check("ar_new", {31'd0, NEW_RECORD}, 32'd1);
    check("ar_best", {16'd0, BEST_SCORE}, 32'd123);
    check("ar_bursts", bursts.size(), 32'd1);

    // Lower score than the stored best.
    do_reset();
    model_on = 1;
    PREVIOUS_SCORES = 16'd500;
    READ_FINISH = 1'b1;
`ifdef SCORES_ALWAYS_WRITE_EN
    exp_q.push_back(32'd20);
`endif
    pulse_save(16'd20);
    wait_done("lower");
    repeat (2) @(negedge CLK);
    check("low_finish", {31'd0, WRITE_FINISH}, 32'd1);
    check("low_new", {31'd0, NEW_RECORD}, 32'd0);
`ifdef SCORES_ALWAYS_WRITE_EN
    check("low_best", {16'd0, BEST_SCORE}, 32'd20);
    check("low_bursts", bursts.size(), 32'd1);
`else
    check("low_best", {16'd0, BEST_SCORE}, 32'd500);
    check("low_bursts", bursts.size(), 32'd0);
`endif
    check("low_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
